// File: rtl/battleship_pkg.sv
// battleship_pkg: shared state encoding, coordinate type and game limits for shot_sequencer
package battleship_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_SHOT, SCORE, DONE} state_t;
    typedef logic [3:0] coord_t;
    localparam logic [4:0] MAX_SHOTS  = 5'd20;
    localparam logic [1:0] MAX_BIG    = 2'd2;
    localparam logic [6:0] SHIP_CELLS = 7'd19;
    localparam coord_t     BOARD_MIN  = 4'd1;
    localparam coord_t     BOARD_MAX  = 4'd10;
    function automatic logic on_board(coord_t c);
        return c >= BOARD_MIN && c <= BOARD_MAX;
    endfunction
    // Row-major cell number 0..99 for on-board coordinates.
    function automatic logic [6:0] cell_idx(coord_t x, coord_t y);
        return 7'(({3'd0, y} - 7'd1) * 7'd10 + {3'd0, x} - 7'd1);
    endfunction
endpackage

// File: rtl/shot_board.sv
// shot_board: 100-cell record of aim cells already fired on, cleared by reset or a new game
module shot_board
    import battleship_pkg::*;
(
    input  logic   clock,
    input  logic   reset_N,
    input  logic   clear,
    input  logic   mark,
    input  coord_t mark_x,
    input  coord_t mark_y,
    input  coord_t x,
    input  coord_t y,
    output logic   fired
);
    logic [99:0] cells;
    always_ff @(posedge clock or negedge reset_N)
        if (!reset_N)
            cells <= '0;
        else if (clear)
            cells <= '0;
        else if (mark)
            cells[cell_idx(mark_x, mark_y)] <= 1'b1;
    assign fired = on_board(x) && on_board(y) && cells[cell_idx(x, y)];
endmodule

// File: rtl/shot_sequencer.sv
// shot_sequencer: accepts shots, drives the hit calculator and keeps the game score.
// Define SHOT_REPEAT_CHECK_EN to reject shots at cells already fired on.
module shot_sequencer
    import battleship_pkg::*;
(
    input  logic       clock,
    input  logic       reset_N,
    input  logic       StartGame,
    input  logic       ShotValid,
    output logic       ShotReady,
    input  coord_t     X,
    input  coord_t     Y,
    input  logic       BigIn,
    output coord_t     CalcX,
    output coord_t     CalcY,
    output logic       CalcBig,
    output logic       ScoreThis,
    input  logic [6:0] NumHits,
    output logic [6:0] HitsTotal,
    output logic [4:0] ShotsTaken,
    output logic [1:0] BigLeft,
    output logic       IllegalShot,
    output logic       GameWon,
    output logic       GameOver
);
    state_t     state, state_nxt;
    logic       shot_ok, take, fired, over_nxt;
    logic [7:0] hits_sum;
    logic [6:0] hits_nxt;
    logic [4:0] shots_nxt;

    assign hits_sum  = {1'b0, HitsTotal} + {1'b0, NumHits};
    assign hits_nxt  = hits_sum[7] ? 7'd127 : hits_sum[6:0];
    assign shots_nxt = ShotsTaken + 5'd1;

`ifdef SHOT_REPEAT_CHECK_EN
    shot_board u_board (
        .clock  (clock),
        .reset_N(reset_N),
        .clear  (StartGame),
        .mark   (ScoreThis && !StartGame),
        .mark_x (CalcX),
        .mark_y (CalcY),
        .x      (X),
        .y      (Y),
        .fired  (fired)
    );
`else
    assign fired = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_N)
        if (!reset_N)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        ShotReady = state == WAIT_SHOT;
        ScoreThis = state == SCORE;
        shot_ok   = on_board(X) && on_board(Y) && !(BigIn && BigLeft == 2'd0) && !fired;
        take      = ShotReady && ShotValid && !StartGame;
        over_nxt  = hits_nxt >= SHIP_CELLS || shots_nxt == MAX_SHOTS;
        state_nxt = StartGame       ? WAIT_SHOT :
                    take && shot_ok ? SCORE :
                    ScoreThis       ? (over_nxt ? DONE : WAIT_SHOT) : state;
    end

    // A new game wins over any shot or score in the same cycle.
    always_ff @(posedge clock or negedge reset_N)
        if (!reset_N) begin
            CalcX       <= '0;
            CalcY       <= '0;
            CalcBig     <= 1'b0;
            HitsTotal   <= '0;
            ShotsTaken  <= '0;
            BigLeft     <= MAX_BIG;
            IllegalShot <= 1'b0;
            GameWon     <= 1'b0;
            GameOver    <= 1'b0;
        end else if (StartGame) begin
            HitsTotal   <= '0;
            ShotsTaken  <= '0;
            BigLeft     <= MAX_BIG;
            IllegalShot <= 1'b0;
            GameWon     <= 1'b0;
            GameOver    <= 1'b0;
        end else begin
            IllegalShot <= take && !shot_ok;
            if (take && shot_ok) begin
                CalcX   <= X;
                CalcY   <= Y;
                CalcBig <= BigIn;
            end
            if (ScoreThis) begin
                HitsTotal  <= hits_nxt;
                ShotsTaken <= shots_nxt;
                BigLeft    <= CalcBig ? BigLeft - 2'd1 : BigLeft;
                GameWon    <= hits_nxt >= SHIP_CELLS;
                GameOver   <= over_nxt;
            end
        end
endmodule

// File: tb/tb_shot_sequencer.sv
// tb_shot_sequencer: directed and randomized checks of shot_sequencer against a game-level model
module tb_shot_sequencer;
    logic       clock = 1'b0, reset_N = 1'b0, StartGame = 1'b0, ShotValid = 1'b0, BigIn = 1'b0;
    logic [3:0] X = 4'd0, Y = 4'd0;
    logic [6:0] NumHits;
    logic       ShotReady, CalcBig, ScoreThis, IllegalShot, GameWon, GameOver;
    logic [3:0] CalcX, CalcY;
    logic [6:0] HitsTotal;
    logic [4:0] ShotsTaken;
    logic [1:0] BigLeft;
    int         checks = 0, errors = 0;
    bit         ovr_en = 1'b0;
    logic [6:0] ovr_val = 7'd0;
    int         m_hits, m_shots, m_big;
    bit         m_won, m_over;
    bit         m_fired [0:15][0:15];

    shot_sequencer dut (
        .clock(clock), .reset_N(reset_N), .StartGame(StartGame), .ShotValid(ShotValid),
        .ShotReady(ShotReady), .X(X), .Y(Y), .BigIn(BigIn), .CalcX(CalcX), .CalcY(CalcY),
        .CalcBig(CalcBig), .ScoreThis(ScoreThis), .NumHits(NumHits), .HitsTotal(HitsTotal),
        .ShotsTaken(ShotsTaken), .BigLeft(BigLeft), .IllegalShot(IllegalShot),
        .GameWon(GameWon), .GameOver(GameOver)
    );

    always #5 clock = ~clock;

    // Fleet of 19 cells: a 3x3 block at x2..4/y1..3, a cell at (5,3), a row at y7 x1..9.
    function automatic bit is_ship(int x, int y);
        return (x >= 2 && x <= 4 && y >= 1 && y <= 3) || (x == 5 && y == 3) || (y == 7 && x >= 1 && x <= 9);
    endfunction

    function automatic int count_hits(int x, int y, bit big);
        int n = 0;
        for (int dx = -1; dx <= 1; dx++)
            for (int dy = -1; dy <= 1; dy++)
                if ((big || (dx == 0 && dy == 0)) && is_ship(x + dx, y + dy)) n++;
        return n;
    endfunction

    always_comb NumHits = !ScoreThis ? 7'd0 : ovr_en ? ovr_val : 7'(count_hits(int'(CalcX), int'(CalcY), CalcBig));

    task automatic model_start();
        m_hits = 0; m_shots = 0; m_big = 2; m_won = 0; m_over = 0;
        for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) m_fired[i][j] = 0;
    endtask

    task automatic model_shot(input int x, input int y, input bit big, output bit legal);
        legal = x >= 1 && x <= 10 && y >= 1 && y <= 10 && !(big && m_big == 0);
`ifdef SHOT_REPEAT_CHECK_EN
        if (legal && m_fired[x][y]) legal = 0;
`endif
        if (legal) begin
            m_hits = m_hits + (ovr_en ? int'(ovr_val) : count_hits(x, y, big));
            if (m_hits > 127) m_hits = 127;
            m_shots++;
            if (big) m_big--;
            m_fired[x][y] = 1;
            m_won = m_hits >= 19;
            m_over = m_won || m_shots == 20;
        end
    endtask

    task automatic start_game();
        @(negedge clock); StartGame = 1;
        @(negedge clock); StartGame = 0;
        model_start();
    endtask

    task automatic fire(input int x, input int y, input bit big,
                        output logic ill1, output logic ill2, output logic sc1,
                        output logic sc2, output logic rdy1, output logic rdy2);
        @(negedge clock); X = 4'(x); Y = 4'(y); BigIn = big; ShotValid = 1;
        @(negedge clock); ill1 = IllegalShot; sc1 = ScoreThis; rdy1 = ShotReady; ShotValid = 0;
        @(negedge clock); ill2 = IllegalShot; sc2 = ScoreThis; rdy2 = ShotReady;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({CalcX, CalcY, CalcBig, ScoreThis, ShotReady, HitsTotal, ShotsTaken, BigLeft, IllegalShot, GameWon, GameOver}
            !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 2'd2, 3'b000}) begin
            errors++; $display("FAIL reset_values: got hits=%0d shots=%0d big=%0d rdy=%b sc=%b", HitsTotal, ShotsTaken, BigLeft, ShotReady, ScoreThis);
        end
        @(negedge clock); reset_N = 1;
        X = 5; Y = 3; ShotValid = 1;
        repeat (3) @(negedge clock);
        checks++;
        if ({ShotReady, ScoreThis, IllegalShot, ShotsTaken} !== {3'b000, 5'd0}) begin
            errors++; $display("FAIL idle_ignore: got rdy=%b sc=%b ill=%b shots=%0d, want 0 0 0 0", ShotReady, ScoreThis, IllegalShot, ShotsTaken);
        end
        ShotValid = 0;
    endtask

    task automatic test_single();
        logic i1, i2, s1, s2, r1, r2;
        start_game();
        checks++;
        if (ShotReady !== 1'b1) begin errors++; $display("FAIL start_ready: got %b want 1", ShotReady); end
        fire(5, 3, 0, i1, i2, s1, s2, r1, r2);
        checks++;
        if ({s1, s2} !== 2'b10) begin errors++; $display("FAIL single_score_pulse: got %b want 10", {s1, s2}); end
        checks++;
        if ({HitsTotal, ShotsTaken, r2} !== {7'd1, 5'd1, 1'b1}) begin
            errors++; $display("FAIL single_counts: got hits=%0d shots=%0d rdy=%b want 1 1 1", HitsTotal, ShotsTaken, r2);
        end
    endtask

    task automatic test_big();
        logic i1, i2, s1, s2, r1, r2;
        start_game();
        fire(3, 2, 1, i1, i2, s1, s2, r1, r2);
        checks++;
        if ({HitsTotal, BigLeft} !== {7'd9, 2'd1}) begin errors++; $display("FAIL big_first: got hits=%0d big=%0d want 9 1", HitsTotal, BigLeft); end
        fire(10, 10, 1, i1, i2, s1, s2, r1, r2);
        checks++;
        if ({HitsTotal, BigLeft, ShotsTaken} !== {7'd9, 2'd0, 5'd2}) begin errors++; $display("FAIL big_second: got hits=%0d big=%0d shots=%0d want 9 0 2", HitsTotal, BigLeft, ShotsTaken); end
        fire(8, 8, 1, i1, i2, s1, s2, r1, r2);
        checks++;
        if ({i1, i2, s1, BigLeft, ShotsTaken} !== {3'b100, 2'd0, 5'd2}) begin
            errors++; $display("FAIL big_third: got ill=%b%b sc=%b big=%0d shots=%0d want 10 0 0 2", i1, i2, s1, BigLeft, ShotsTaken);
        end
    endtask

    task automatic test_illegal_coord();
        logic i1, i2, s1, s2, r1, r2;
        start_game();
        fire(5, 3, 0, i1, i2, s1, s2, r1, r2);
        for (int k = 0; k < 4; k++) begin
            int xs [4] = '{0, 11, 5, 5};
            int ys [4] = '{5, 5, 0, 15};
            fire(xs[k], ys[k], 0, i1, i2, s1, s2, r1, r2);
            checks++;
            if ({i1, i2, s1, r1, r2, HitsTotal, ShotsTaken} !== {5'b10011, 7'd1, 5'd1}) begin
                errors++; $display("FAIL illegal_coord(%0d,%0d): got ill=%b%b sc=%b rdy=%b%b hits=%0d shots=%0d", xs[k], ys[k], i1, i2, s1, r1, r2, HitsTotal, ShotsTaken);
            end
        end
    endtask

    task automatic test_game_over();
        logic i1, i2, s1, s2, r1, r2;
        start_game();
        for (int k = 0; k < 20; k++) begin
`ifdef SHOT_REPEAT_CHECK_EN
            fire(k % 10 + 1, 9 + k / 10, 0, i1, i2, s1, s2, r1, r2);
`else
            fire(10, 10, 0, i1, i2, s1, s2, r1, r2);
`endif
            if (k == 18) begin
                checks++;
                if ({GameOver, r2} !== 2'b01) begin errors++; $display("FAIL over_early: got over=%b rdy=%b want 0 1", GameOver, r2); end
            end
        end
        checks++;
        if ({GameOver, GameWon, r2, ShotsTaken, HitsTotal} !== {3'b100, 5'd20, 7'd0}) begin
            errors++; $display("FAIL game_over: got over=%b won=%b rdy=%b shots=%0d hits=%0d want 1 0 0 20 0", GameOver, GameWon, r2, ShotsTaken, HitsTotal);
        end
        fire(5, 3, 0, i1, i2, s1, s2, r1, r2);
        checks++;
        if ({i1, s1, ShotsTaken, GameOver, ShotReady} !== {2'b00, 5'd20, 2'b10}) begin
            errors++; $display("FAIL done_hold: got ill=%b sc=%b shots=%0d over=%b rdy=%b", i1, s1, ShotsTaken, GameOver, ShotReady);
        end
        start_game();
        checks++;
        if ({ShotReady, GameOver, ShotsTaken, BigLeft} !== {2'b10, 5'd0, 2'd2}) begin
            errors++; $display("FAIL done_restart: got rdy=%b over=%b shots=%0d big=%0d", ShotReady, GameOver, ShotsTaken, BigLeft);
        end
    endtask

    task automatic test_saturate();
        logic i1, i2, s1, s2, r1, r2;
        start_game();
        ovr_en = 1; ovr_val = 7'd18;
        fire(10, 10, 0, i1, i2, s1, s2, r1, r2);
        checks++;
        if ({HitsTotal, GameWon, r2} !== {7'd18, 2'b01}) begin errors++; $display("FAIL sat_first: got hits=%0d won=%b rdy=%b want 18 0 1", HitsTotal, GameWon, r2); end
        ovr_val = 7'd127;
        fire(10, 9, 0, i1, i2, s1, s2, r1, r2);
        checks++;
        if ({HitsTotal, GameWon, GameOver, r2} !== {7'd127, 3'b110}) begin
            errors++; $display("FAIL saturate: got hits=%0d won=%b over=%b rdy=%b want 127 1 1 0", HitsTotal, GameWon, GameOver, r2);
        end
        ovr_en = 0;
    endtask

    task automatic test_repeat();
        logic i1, i2, s1, s2, r1, r2;
        start_game();
        fire(5, 3, 0, i1, i2, s1, s2, r1, r2);
        fire(5, 3, 0, i1, i2, s1, s2, r1, r2);
        checks++;
`ifdef SHOT_REPEAT_CHECK_EN
        if ({i1, HitsTotal, ShotsTaken} !== {1'b1, 7'd1, 5'd1}) begin
            errors++; $display("FAIL repeat: got ill=%b hits=%0d shots=%0d want 1 1 1", i1, HitsTotal, ShotsTaken);
        end
`else
        if ({i1, HitsTotal, ShotsTaken} !== {1'b0, 7'd2, 5'd2}) begin
            errors++; $display("FAIL repeat: got ill=%b hits=%0d shots=%0d want 0 2 2", i1, HitsTotal, ShotsTaken);
        end
`endif
    endtask

    task automatic test_reset_mid_score();
        logic i1, i2, s1, s2, r1, r2;
        start_game();
        fire(3, 2, 0, i1, i2, s1, s2, r1, r2);
        @(negedge clock); X = 5; Y = 3; BigIn = 1; ShotValid = 1;
        @(posedge clock); #1 ShotValid = 0;
        checks++;
        if (ScoreThis !== 1'b1) begin errors++; $display("FAIL mid_score_entry: got sc=%b want 1", ScoreThis); end
        #1 reset_N = 0;
        #1;
        checks++;
        if ({CalcX, CalcY, CalcBig, ScoreThis, ShotReady, HitsTotal, ShotsTaken, BigLeft, IllegalShot, GameWon, GameOver}
            !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 2'd2, 3'b000}) begin
            errors++; $display("FAIL async_reset: got hits=%0d shots=%0d big=%0d sc=%b rdy=%b calc=%0d,%0d", HitsTotal, ShotsTaken, BigLeft, ScoreThis, ShotReady, CalcX, CalcY);
        end
        @(negedge clock); reset_N = 1;
        repeat (2) @(negedge clock);
        checks++;
        if ({HitsTotal, ShotsTaken, ShotReady} !== {7'd0, 5'd0, 1'b0}) begin
            errors++; $display("FAIL reset_discard: got hits=%0d shots=%0d rdy=%b want 0 0 0", HitsTotal, ShotsTaken, ShotReady);
        end
    endtask

    task automatic test_start_priority();
        logic i1, i2, s1, s2, r1, r2;
        start_game();
        fire(5, 3, 0, i1, i2, s1, s2, r1, r2);
        @(negedge clock); StartGame = 1; ShotValid = 1; X = 3; Y = 2; BigIn = 1;
        @(negedge clock); StartGame = 0; ShotValid = 0;
        checks++;
        if ({ScoreThis, ShotReady, HitsTotal, ShotsTaken, BigLeft} !== {2'b01, 7'd0, 5'd0, 2'd2}) begin
            errors++; $display("FAIL start_with_shot: got sc=%b rdy=%b hits=%0d shots=%0d big=%0d", ScoreThis, ShotReady, HitsTotal, ShotsTaken, BigLeft);
        end
        @(negedge clock); ShotValid = 1; X = 3; Y = 2; BigIn = 1;
        @(negedge clock); ShotValid = 0; StartGame = 1;
        checks++;
        if (ScoreThis !== 1'b1) begin errors++; $display("FAIL score_before_start: got sc=%b want 1", ScoreThis); end
        @(negedge clock); StartGame = 0;
        checks++;
        if ({HitsTotal, ShotsTaken, BigLeft, ShotReady, ScoreThis} !== {7'd0, 5'd0, 2'd2, 2'b10}) begin
            errors++; $display("FAIL start_in_score: got hits=%0d shots=%0d big=%0d rdy=%b sc=%b", HitsTotal, ShotsTaken, BigLeft, ShotReady, ScoreThis);
        end
        model_start();
    endtask

    task automatic test_random();
        logic i1, i2, s1, s2, r1, r2;
        bit legal, big;
        int x, y;
        start_game();
        for (int n = 0; n < 150; n++) begin
            if (m_over) start_game();
            x = $urandom_range(0, 11);
            y = $urandom_range(0, 11);
            big = $urandom_range(0, 3) == 0;
            model_shot(x, y, big, legal);
            fire(x, y, big, i1, i2, s1, s2, r1, r2);
            checks++;
            if ({i1, i2, s1, s2, HitsTotal, ShotsTaken, BigLeft, GameWon, GameOver, r2}
                !== {!legal, 1'b0, legal, 1'b0, 7'(m_hits), 5'(m_shots), 2'(m_big), m_won, m_over, !m_over}) begin
                errors++;
                $display("FAIL random(%0d,%0d,big=%b): got ill=%b%b sc=%b%b hits=%0d shots=%0d big=%0d won=%b over=%b rdy=%b; want ill=%b hits=%0d shots=%0d big=%0d won=%b over=%b",
                         x, y, big, i1, i2, s1, s2, HitsTotal, ShotsTaken, BigLeft, GameWon, GameOver, r2, !legal, m_hits, m_shots, m_big, m_won, m_over);
            end
        end
    endtask

    initial begin
        model_start();
        test_reset();
        test_single();
        test_big();
        test_illegal_coord();
        test_game_over();
        test_saturate();
        test_repeat();
        test_reset_mid_score();
        test_start_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/shot_sequencer.md
SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-002 SHALL have port reset_N, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port StartGame, input, 1 bit: clears the game and arms the sequencer.
REQ-004 SHALL have ports ShotValid (input, 1 bit) and ShotReady (output, 1 bit): shot request handshake.
REQ-005 SHALL have ports X and Y, input, 4 bits each: requested coordinates, legal range 1..10.
REQ-006 SHALL have port BigIn, input, 1 bit: the requested shot is a 3x3 big shot.
REQ-007 SHALL have ports CalcX and CalcY (output, 4 bits each), CalcBig (output, 1 bit) and ScoreThis (output, 1 bit): drive the hit calculator.
REQ-008 SHALL have port NumHits, input, 7 bits: combinational response of the hit calculator to the Calc* outputs.
REQ-009 SHALL have outputs HitsTotal (7 bits), ShotsTaken (5 bits) and BigLeft (2 bits).
REQ-010 SHALL have outputs IllegalShot, GameWon and GameOver, 1 bit each.

Function
REQ-011 FSM states SHALL be IDLE, WAIT_SHOT, SCORE and DONE.
REQ-012 IDLE SHALL go to WAIT_SHOT on StartGame; all other inputs are ignored in IDLE.
REQ-013 ShotReady SHALL be 1 only in WAIT_SHOT; a shot is accepted when ShotValid and ShotReady are both 1 at a clock edge.
REQ-014 A shot is illegal when X or Y is outside 1..10, or when BigIn=1 and BigLeft=0.
REQ-015 An illegal shot SHALL pulse IllegalShot for exactly 1 cycle, change no counter, and leave the FSM in WAIT_SHOT.
REQ-016 A legal accepted shot SHALL register X, Y and BigIn into CalcX, CalcY and CalcBig, then move to SCORE.
REQ-017 In SCORE, ScoreThis SHALL be 1 for exactly 1 cycle; in every other state ScoreThis SHALL be 0.
REQ-018 At the end of SCORE, HitsTotal += NumHits, saturating at 127.
REQ-019 At the end of SCORE, ShotsTaken SHALL increment by 1, and BigLeft SHALL decrement by 1 when CalcBig=1.
REQ-020 Accept-to-updated-HitsTotal latency SHALL be 2 cycles.
REQ-021 GameWon SHALL be set when the updated HitsTotal >= 19.
REQ-022 GameOver SHALL be set when GameWon is set or ShotsTaken reaches 20.
REQ-023 After SCORE, the FSM SHALL go to DONE if GameOver is set, otherwise to WAIT_SHOT.
REQ-024 DONE SHALL hold all outputs until StartGame.
REQ-025 StartGame in any state SHALL take priority over every other event: HitsTotal=0, ShotsTaken=0, BigLeft=2, flags cleared, next state WAIT_SHOT. A simultaneous shot SHALL be dropped.
REQ-026 StartGame during SCORE SHALL discard that cycle's NumHits.

Reset
REQ-027 On reset_N=0, asynchronously: state=IDLE, CalcX=CalcY=0, CalcBig=0, ScoreThis=0, ShotReady=0, HitsTotal=0, ShotsTaken=0, BigLeft=2, IllegalShot=GameWon=GameOver=0.
REQ-028 Reset asserted mid-SCORE SHALL discard the shot in progress.

Configuration
REQ-029 Macro SHOT_REPEAT_CHECK_EN defined: a 100-entry fired-cell record SHALL be kept; it is set for (X,Y) on each scored shot and cleared by StartGame or reset.
REQ-030 With SHOT_REPEAT_CHECK_EN defined, a shot at an already-fired (X,Y) SHALL be illegal (REQ-015 applies). Only the aim cell is recorded, not the big-shot neighbours.
REQ-031 With SHOT_REPEAT_CHECK_EN undefined, there SHALL be no record and repeated shots SHALL be legal and scored again.

Structure
REQ-032 Package battleship_pkg SHALL hold the state enum, coord_t (4 bits) and the constants MAX_SHOTS=20, MAX_BIG=2, SHIP_CELLS=19, BOARD_MIN=1, BOARD_MAX=10.
REQ-033 Sub-module shot_board SHALL implement the fired-cell record, instantiated only under SHOT_REPEAT_CHECK_EN.

Verification (bench connects the team's hit calculator to Calc*/ScoreThis/NumHits)
REQ-034 Start; shot (5,3), BigIn=0 -> ScoreThis pulses 1 cycle, HitsTotal=1, ShotsTaken=1.
REQ-035 Start; shot (3,2), BigIn=1 -> HitsTotal=9, BigLeft=1. A third big shot -> IllegalShot pulse, BigLeft stays 0.
REQ-036 Shot (0,5) or (11,5) -> IllegalShot pulse; HitsTotal and ShotsTaken unchanged; ShotReady stays 1.
REQ-037 20 legal misses at (10,10) (macro undefined) -> after the 20th, GameOver=1, GameWon=0, state DONE, ShotReady=0.
REQ-038 Macro defined, (5,3) twice -> second shot IllegalShot; macro undefined -> HitsTotal=2.
REQ-039 reset_N low during SCORE -> all outputs at reset values immediately. StartGame together with ShotValid -> counters 0, shot dropped.
